// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   SEG_0..SEG_9, SEG_BLANK : active-low cathode patterns, bit order {g,f,e,d,c,b,a}
//   bcd_t                   : one BCD digit
//   conv_state_e            : state encoding of the sequential binary-to-BCD converter
//   pow10()                 : constant function, 10**n
//   seg_decode()            : BCD digit to cathode pattern; codes 10..15 give blank
package sevenseg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter, one iteration per clock.
//   clk, rst_n : system clock, async active-low reset
//   start      : capture value and begin (accepted whenever busy is low, including in DONE)
//   value      : binary input, already saturated so it fits DIGITS decimal digits
//   busy       : high while converting
//   done       : one-cycle pulse; bcd holds the finished result during it
//   bcd        : packed BCD result, digit 0 in the low nibble
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SR_W  = 4 * DIGITS + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        adj     = sr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StConv;
                    sr_d    = {{(4*DIGITS){1'b0}}, value};
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StConv: begin
                // After the last shift one more CONV cycle elapses, giving a busy
                // window of BIN_W+1 cycles before the DONE handoff.
                if (cnt_q == CNT_W'(BIN_W)) begin
                    state_d = StDone;
                end else begin
                    sr_d  = adj << 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StConv);
    assign done = (state_q == StDone);
    assign bcd  = sr_q[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed active-low 7-segment driver with sequential binary-to-BCD conversion.
// Optional macro SEVENSEG_BLANK_LEADING_EN blanks leading zero digits (digit 0 never blanked).
//   clk, rst_n : 100 MHz system clock, async active-low reset
//   scan_tick  : enable pulse advancing the scanned digit
//   load       : capture value_in and start conversion (ignored while busy)
//   value_in   : binary value, saturated to 10**DIGITS-1
//   busy       : conversion in progress
//   ovf        : last accepted value was saturated
//   an         : anodes, active-low, one-hot-low once scanning
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, held off
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_tick,
    input  logic              load,
    input  logic [BIN_W-1:0]  value_in,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int unsigned      IDX_W  = $clog2(DIGITS);
    localparam int unsigned      MaxVal = pow10(DIGITS) - 1;
    localparam logic [BIN_W-1:0] MaxBin = BIN_W'(MaxVal);

    logic                  over, accept, conv_busy, conv_done;
    logic [BIN_W-1:0]      sat_val;
    logic [4*DIGITS-1:0]   conv_bcd, disp_q, disp_d;
    logic                  ovf_q, started_q, started_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    bcd_t                  nib;
    logic                  blank;

    assign over    = 32'(value_in) > MaxVal;
    assign sat_val = over ? MaxBin : value_in;
    assign accept  = load && !conv_busy;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .value (sat_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Whole-register swap on done: the display never shows a partial result.
    assign disp_d = conv_done ? conv_bcd : disp_q;

    // The first tick only starts scanning at digit 0; later ticks advance.
    always_comb begin
        started_d = started_q;
        idx_d     = idx_q;
        if (scan_tick) begin
            if (!started_q) begin
                started_d = 1'b1;
            end else if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Decode from next-state display/index so a coincident update shows at once.
    always_comb begin
        nib   = disp_d[4*idx_d +: 4];
        blank = 1'b0;
`ifdef SEVENSEG_BLANK_LEADING_EN
        blank = (idx_d != '0);
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) >= idx_d && disp_d[4*j +: 4] != 4'd0) begin
                blank = 1'b0;
            end
        end
`endif
        an_d  = started_d ? ~(DIGITS'(1) << idx_d) : '1;
        seg_d = (!started_d || blank) ? SEG_BLANK : seg_decode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            started_q <= 1'b0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            disp_q    <= disp_d;
            if (accept) begin
                ovf_q <= over;
            end
            started_q <= started_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = conv_busy;
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;
    import sevenseg_pkg::*;

    localparam int D = 4;
    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scan_tick = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] value_in = '0;
    logic         busy, ovf, dp;
    logic [D-1:0] an;
    logic [6:0]   seg;

    int checks = 0;
    int errors = 0;

    // Reference model: decimal value shown, pending load with cycles-to-update.
    int m_disp, m_pval, m_pend, m_idx;
    bit m_ovf, m_started;
    logic [6:0] seg_tab [10];

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.DIGITS(D), .BIN_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_tick (scan_tick),
        .load      (load),
        .value_in  (value_in),
        .busy      (busy),
        .ovf       (ovf),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg();
        int dig;
        if (!m_started) return 7'h7F;
        dig = (m_disp / p10(m_idx)) % 10;
`ifdef SEVENSEG_BLANK_LEADING_EN
        if (m_idx > 0 && m_disp < p10(m_idx)) return 7'h7F;
`endif
        return seg_tab[dig];
    endfunction

    function automatic logic [D-1:0] exp_an();
        logic [D-1:0] a;
        a = '1;
        if (m_started) a[m_idx] = 1'b0;
        return a;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_pval = 0; m_pend = 0; m_idx = 0; m_ovf = 0; m_started = 0;
    endtask

    // Applied once per clock edge with the inputs that edge sampled.
    task automatic model_edge(input bit ld, input int val, input bit tk);
        int maxv;
        maxv = p10(D) - 1;
        if (m_pend == 1) m_disp = m_pval;
        if (ld && m_pend <= 1) begin
            m_pend = W + 2;
            m_pval = (val > maxv) ? maxv : val;
            m_ovf  = (val > maxv);
        end else if (m_pend > 0) begin
            m_pend--;
        end
        if (tk) begin
            if (m_started) m_idx = (m_idx + 1) % D;
            else m_started = 1;
        end
    endtask

    task automatic check_all();
        chk("an", 32'(an), 32'(exp_an()));
        chk("seg", 32'(seg), 32'(exp_seg()));
        chk("busy", 32'(busy), 32'(m_pend > 1));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("dp", 32'(dp), 32'd1);
    endtask

    task automatic cycle(input bit ld, input int val, input bit tk);
        load = ld;
        value_in = W'(val);
        scan_tick = tk;
        @(posedge clk);
        #1;
        model_edge(ld, val, tk);
        check_all();
        load = 1'b0;
        scan_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    // Async reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset();
        load = 1'b0;
        scan_tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int bc;
        logic [D-1:0] an_seq [4];
        logic [6:0]   seg_seq [4];
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        an_seq  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        seg_seq = '{7'h30, 7'h24, 7'h79, 7'h19};
        model_reset();

        #12;
        rst_n = 1'b1;
        idle(3);
        chk("init_an", 32'(an), 32'hF);
        chk("init_seg", 32'(seg), 32'h7F);

        cycle(0, 0, 1);
        chk("first_tick_an", 32'(an), 32'b1110);
        chk("first_tick_seg", 32'(seg), 32'h40);

        // 1234: busy window length, then digits over four ticks.
        cycle(1, 1234, 0);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0);
            if (busy) bc++;
            else break;
        end
        chk("busy_len", 32'(bc), 32'd15);
        chk("disp_hold_during_done", 32'(seg), 32'h40);
        cycle(0, 0, 0);
        chk("disp_1234_d0", 32'(seg), 32'h19);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            chk("scan_an", 32'(an), 32'(an_seq[i]));
            chk("scan_seg", 32'(seg), 32'(seg_seq[i]));
        end

        // Saturation and ovf clear.
        cycle(1, 12000, 0);
        idle(17);
        chk("ovf_set", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        cycle(1, 7, 0);
        idle(17);
        chk("ovf_clr", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        // Load while busy ignored; load in the cycle busy falls accepted.
        cycle(1, 5, 0);
        idle(2);
        cycle(1, 9, 0);
        for (int i = 0; i < 40 && m_pend != 1; i++) cycle(0, 0, 0);
        chk("reach_done", 32'(m_pend), 32'd1);
        cycle(1, 9, 0);
        chk("disp_5", 32'(m_disp), 32'd5);
        idle(17);
        chk("disp_9", 32'(m_disp), 32'd9);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        // Reset mid-conversion, then no spurious update afterwards.
        cycle(1, 4321, 0);
        idle(5);
        do_reset();
        idle(20);
        cycle(0, 0, 1);
        chk("post_rst_seg", 32'(seg), 32'h40);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 16383),
                  ($urandom_range(0, 3) == 0));
            if (m_started) chk("one_hot_low", 32'($countones(~an)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
